// File: rtl/ms_sb_pkg.sv
// Shared constants and FSM encoding for the span-buffer controller.
// Optional watermark outputs are enabled with MS_SBCTL_WMARK_EN.
package ms_sb_pkg;
   localparam int SB_REGION_DEPTH = 8;
   localparam int SB_PTR_W        = 4;
   localparam int SB_IDX_W        = 3;
   localparam logic [SB_PTR_W-1:0] SB_WMARK_LVL = 4'd6;

   typedef enum logic [1:0] {
      SB_IDLE  = 2'd0,
      SB_RUN   = 2'd1,
      SB_FLUSH = 2'd2
   } sb_state_e;
endpackage

// File: rtl/ms_sb_ptr.sv
// Read/write pointer pair for one 8-entry span-buffer region, with full/empty/occupancy.
// MS_SBCTL_WMARK_EN adds a high-occupancy watermark output.
module ms_sb_ptr
   import ms_sb_pkg::*;
(
   input  logic                clock,
   input  logic                reset_l,
   input  logic                inc_w_i,
   input  logic                inc_r_i,
   input  logic                clr_i,
   output logic [SB_PTR_W-1:0] wptr_o,
   output logic [SB_PTR_W-1:0] rptr_o,
   output logic                full_o,
   output logic                empty_o
`ifdef MS_SBCTL_WMARK_EN
   ,
   output logic                wmark_o
`endif
);
   logic [SB_PTR_W-1:0] wptr_q, wptr_d;
   logic [SB_PTR_W-1:0] rptr_q, rptr_d;
   logic [SB_PTR_W-1:0] occ;

   always_comb begin
      wptr_d = wptr_q + {{(SB_PTR_W-1){1'b0}}, inc_w_i};
      rptr_d = rptr_q + {{(SB_PTR_W-1){1'b0}}, inc_r_i};
      if (clr_i) begin
         wptr_d = '0;
         rptr_d = '0;
      end
   end

   always_ff @(posedge clock or negedge reset_l) begin
      if (!reset_l) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   // Modulo-16 difference; always 0..8 because the wrap bit separates full from empty.
   assign occ     = wptr_q - rptr_q;
   assign wptr_o  = wptr_q;
   assign rptr_o  = rptr_q;
   assign empty_o = (occ == '0);
   assign full_o  = (wptr_q[SB_PTR_W-1] != rptr_q[SB_PTR_W-1]) &&
                    (wptr_q[SB_IDX_W-1:0] == rptr_q[SB_IDX_W-1:0]);
`ifdef MS_SBCTL_WMARK_EN
   assign wmark_o = (occ >= SB_WMARK_LVL);
`endif
endmodule

// File: rtl/ms_sbctl.sv
// Span-buffer controller: arbitrates color/Z fills onto port 0 and drains onto port 1.
// MS_SBCTL_WMARK_EN adds wmark_c/wmark_z occupancy outputs.
module ms_sbctl
   import ms_sb_pkg::*;
(
   input  logic                clock,
   input  logic                reset_l,
   input  logic                sb_enable,
   input  logic                sb_flush,
   input  logic                fill_c_valid,
   input  logic                fill_z_valid,
   output logic                fill_c_ready,
   output logic                fill_z_ready,
   input  logic                drain_c_req,
   input  logic                drain_z_req,
   output logic                drain_c_gnt,
   output logic                drain_z_gnt,
   output logic                rd_c_valid,
   output logic                rd_z_valid,
   output logic                we0,
   output logic                we1,
   output logic [SB_PTR_W-1:0] addr0,
   output logic [SB_PTR_W-1:0] addr1,
   output logic                fill_sel_z,
   output logic [SB_PTR_W-1:0] rbcrptr,
   output logic [SB_PTR_W-1:0] rbcwptr,
   output logic [SB_PTR_W-1:0] rbzrptr,
   output logic [SB_PTR_W-1:0] rbzwptr,
   output logic                stallcr,
   output logic                stallcw,
   output logic                stallzr,
   output logic                stallzw
`ifdef MS_SBCTL_WMARK_EN
   ,
   output logic                wmark_c,
   output logic                wmark_z
`endif
);
   sb_state_e state_q, state_d;
   logic      last_fill_z_q, last_fill_z_d;
   logic      last_drain_z_q, last_drain_z_d;
   logic      rd_c_valid_q, rd_z_valid_q;
   logic      run, flush_now;
   logic      fill_c_elig, fill_z_elig, drain_c_elig, drain_z_elig;

   assign run       = (state_q == SB_RUN);
   assign flush_now = (state_q == SB_FLUSH);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         SB_IDLE:  if (sb_flush) state_d = SB_FLUSH;
                   else if (sb_enable) state_d = SB_RUN;
         SB_RUN:   if (sb_flush) state_d = SB_FLUSH;
                   else if (!sb_enable) state_d = SB_IDLE;
         SB_FLUSH: state_d = SB_IDLE;
         default:  state_d = SB_IDLE;
      endcase
   end

   // Eligibility uses registered full/empty only: no same-cycle fill/drain bypass.
   always_comb begin
      fill_c_elig  = run && fill_c_valid && !stallcw;
      fill_z_elig  = run && fill_z_valid && !stallzw;
      drain_c_elig = run && drain_c_req && !stallcr;
      drain_z_elig = run && drain_z_req && !stallzr;

      fill_c_ready = fill_c_elig && (!fill_z_elig || last_fill_z_q);
      fill_z_ready = fill_z_elig && !fill_c_ready;
      drain_c_gnt  = drain_c_elig && (!drain_z_elig || last_drain_z_q);
      drain_z_gnt  = drain_z_elig && !drain_c_gnt;

      we0        = fill_c_ready || fill_z_ready;
      we1        = 1'b0;
      fill_sel_z = fill_z_ready;

      addr0 = '0;
      if (fill_c_ready)      addr0 = {1'b0, rbcwptr[SB_IDX_W-1:0]};
      else if (fill_z_ready) addr0 = {1'b1, rbzwptr[SB_IDX_W-1:0]};
      addr1 = '0;
      if (drain_c_gnt)       addr1 = {1'b0, rbcrptr[SB_IDX_W-1:0]};
      else if (drain_z_gnt)  addr1 = {1'b1, rbzrptr[SB_IDX_W-1:0]};

      last_fill_z_d  = we0 ? fill_z_ready : last_fill_z_q;
      last_drain_z_d = (drain_c_gnt || drain_z_gnt) ? drain_z_gnt : last_drain_z_q;
   end

   always_ff @(posedge clock or negedge reset_l) begin
      if (!reset_l) begin
         state_q        <= SB_IDLE;
         last_fill_z_q  <= 1'b1;
         last_drain_z_q <= 1'b1;
         rd_c_valid_q   <= 1'b0;
         rd_z_valid_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         last_fill_z_q  <= last_fill_z_d;
         last_drain_z_q <= last_drain_z_d;
         rd_c_valid_q   <= drain_c_gnt;
         rd_z_valid_q   <= drain_z_gnt;
      end
   end

   assign rd_c_valid = rd_c_valid_q;
   assign rd_z_valid = rd_z_valid_q;

   ms_sb_ptr u_ptr_c (
      .clock   (clock),
      .reset_l (reset_l),
      .inc_w_i (fill_c_ready),
      .inc_r_i (drain_c_gnt),
      .clr_i   (flush_now),
      .wptr_o  (rbcwptr),
      .rptr_o  (rbcrptr),
      .full_o  (stallcw),
      .empty_o (stallcr)
`ifdef MS_SBCTL_WMARK_EN
      ,
      .wmark_o (wmark_c)
`endif
   );

   ms_sb_ptr u_ptr_z (
      .clock   (clock),
      .reset_l (reset_l),
      .inc_w_i (fill_z_ready),
      .inc_r_i (drain_z_gnt),
      .clr_i   (flush_now),
      .wptr_o  (rbzwptr),
      .rptr_o  (rbzrptr),
      .full_o  (stallzw),
      .empty_o (stallzr)
`ifdef MS_SBCTL_WMARK_EN
      ,
      .wmark_o (wmark_z)
`endif
   );
endmodule

// File: tb/tb_ms_sbctl.sv
// Self-checking bench for ms_sbctl: directed scenarios plus a randomized run against a counter-based model.
module tb_ms_sbctl;
   logic       clock, reset_l, sb_enable, sb_flush;
   logic       fill_c_valid, fill_z_valid, fill_c_ready, fill_z_ready;
   logic       drain_c_req, drain_z_req, drain_c_gnt, drain_z_gnt;
   logic       rd_c_valid, rd_z_valid, we0, we1, fill_sel_z;
   logic [3:0] addr0, addr1, rbcrptr, rbcwptr, rbzrptr, rbzwptr;
   logic       stallcr, stallcw, stallzr, stallzw;
   int         checks = 0;
   int         errors = 0;

   ms_sbctl dut (
      .clock(clock), .reset_l(reset_l), .sb_enable(sb_enable), .sb_flush(sb_flush),
      .fill_c_valid(fill_c_valid), .fill_z_valid(fill_z_valid),
      .fill_c_ready(fill_c_ready), .fill_z_ready(fill_z_ready),
      .drain_c_req(drain_c_req), .drain_z_req(drain_z_req),
      .drain_c_gnt(drain_c_gnt), .drain_z_gnt(drain_z_gnt),
      .rd_c_valid(rd_c_valid), .rd_z_valid(rd_z_valid),
      .we0(we0), .we1(we1), .addr0(addr0), .addr1(addr1), .fill_sel_z(fill_sel_z),
      .rbcrptr(rbcrptr), .rbcwptr(rbcwptr), .rbzrptr(rbzrptr), .rbzwptr(rbzwptr),
      .stallcr(stallcr), .stallcw(stallcw), .stallzr(stallzr), .stallzw(stallzw)
   );

   wire [36:0] obs = {fill_c_ready, fill_z_ready, drain_c_gnt, drain_z_gnt, we0, we1,
                      fill_sel_z, rd_c_valid, rd_z_valid, addr0, addr1,
                      rbcrptr, rbcwptr, rbzrptr, rbzwptr, stallcr, stallcw, stallzr, stallzw};

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_inputs();
      sb_enable = 0; sb_flush = 0;
      fill_c_valid = 0; fill_z_valid = 0; drain_c_req = 0; drain_z_req = 0;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset_l = 0;
      tick();
      tick();
      reset_l = 1;
   endtask

   task automatic enable_run();
      sb_enable = 1;
      tick();
   endtask

   task automatic test_reset();
      clear_inputs();
      reset_l = 0;
      sb_enable = 1; fill_c_valid = 1; fill_z_valid = 1; drain_c_req = 1; drain_z_req = 1;
      #2;
      checks++;
      if ({fill_c_ready, fill_z_ready, drain_c_gnt, drain_z_gnt, we0, we1, rd_c_valid, rd_z_valid} !== 8'h00) begin
         errors++; $display("FAIL reset_ctl got %b exp 00000000",
            {fill_c_ready, fill_z_ready, drain_c_gnt, drain_z_gnt, we0, we1, rd_c_valid, rd_z_valid});
      end
      checks++;
      if ({addr0, addr1} !== 8'h00) begin
         errors++; $display("FAIL reset_addr got %h exp 00", {addr0, addr1});
      end
      checks++;
      if ({rbcrptr, rbcwptr, rbzrptr, rbzwptr} !== 16'h0000) begin
         errors++; $display("FAIL reset_ptrs got %h exp 0000", {rbcrptr, rbcwptr, rbzrptr, rbzwptr});
      end
      checks++;
      if ({stallcr, stallcw, stallzr, stallzw} !== 4'b1010) begin
         errors++; $display("FAIL reset_stall got %b exp 1010", {stallcr, stallcw, stallzr, stallzw});
      end
      tick();
      checks++;
      if ({fill_c_ready, we0, rbcwptr} !== 6'h00) begin
         errors++; $display("FAIL reset_hold got %h exp 00", {fill_c_ready, we0, rbcwptr});
      end
      reset_l = 1;
      clear_inputs();
   endtask

   task automatic test_fill_full();
      do_reset();
      enable_run();
      fill_c_valid = 1;
      for (int i = 0; i < 9; i++) begin
         @(negedge clock);
         checks++;
         if (fill_c_ready !== (i < 8)) begin
            errors++; $display("FAIL fill_full_ready[%0d] got %b exp %b", i, fill_c_ready, (i < 8));
         end
         if (i < 8) begin
            checks++;
            if ({we0, addr0} !== {1'b1, i[3:0]}) begin
               errors++; $display("FAIL fill_full_addr[%0d] got %h exp %h", i, {we0, addr0}, {1'b1, i[3:0]});
            end
         end
         tick();
      end
      @(negedge clock);
      checks++;
      if ({stallcw, stallcr, rbcwptr} !== {2'b10, 4'h8}) begin
         errors++; $display("FAIL fill_full_state got %h exp %h", {stallcw, stallcr, rbcwptr}, {2'b10, 4'h8});
      end
      tick();
   endtask

   // Runs straight after test_fill_full with the color region holding 8 entries.
   task automatic test_full_drain();
      fill_c_valid = 1; drain_c_req = 1;
      @(negedge clock);
      checks++;
      if ({drain_c_gnt, fill_c_ready, addr1} !== {2'b10, 4'h0}) begin
         errors++; $display("FAIL full_drain_same got %h exp %h", {drain_c_gnt, fill_c_ready, addr1}, {2'b10, 4'h0});
      end
      tick();
      @(negedge clock);
      checks++;
      if ({fill_c_ready, rd_c_valid, addr0} !== {2'b11, 4'h0}) begin
         errors++; $display("FAIL full_drain_next got %h exp %h", {fill_c_ready, rd_c_valid, addr0}, {2'b11, 4'h0});
      end
      tick();
      clear_inputs();
   endtask

   task automatic test_rr_fill();
      logic       z;
      logic [3:0] ea;
      do_reset();
      enable_run();
      fill_c_valid = 1; fill_z_valid = 1;
      for (int i = 0; i < 4; i++) begin
         z  = (i % 2) == 1;
         ea = 4'(i / 2 + 8 * (i % 2));
         @(negedge clock);
         checks++;
         if ({fill_c_ready, fill_z_ready, fill_sel_z, addr0} !== {!z, z, z, ea}) begin
            errors++; $display("FAIL rr_fill[%0d] got %h exp %h", i,
               {fill_c_ready, fill_z_ready, fill_sel_z, addr0}, {!z, z, z, ea});
         end
         tick();
      end
      clear_inputs();
   endtask

   task automatic test_empty_z();
      do_reset();
      enable_run();
      fill_z_valid = 1; drain_z_req = 1;
      @(negedge clock);
      checks++;
      if ({fill_z_ready, drain_z_gnt, addr0} !== {2'b10, 4'h8}) begin
         errors++; $display("FAIL empty_z_same got %h exp %h", {fill_z_ready, drain_z_gnt, addr0}, {2'b10, 4'h8});
      end
      tick();
      fill_z_valid = 0;
      @(negedge clock);
      checks++;
      if ({drain_z_gnt, addr1} !== {1'b1, 4'h8}) begin
         errors++; $display("FAIL empty_z_next got %h exp %h", {drain_z_gnt, addr1}, {1'b1, 4'h8});
      end
      tick();
      drain_z_req = 0;
      @(negedge clock);
      checks++;
      if ({rd_z_valid, stallzr} !== 2'b11) begin
         errors++; $display("FAIL empty_z_rd got %b exp 11", {rd_z_valid, stallzr});
      end
      clear_inputs();
   endtask

   task automatic test_wrap();
      logic [3:0] idx;
      do_reset();
      enable_run();
      for (int i = 0; i < 16; i++) begin
         idx = 4'(i % 8);
         fill_c_valid = 1;
         @(negedge clock);
         checks++;
         if ({fill_c_ready, addr0, rbcwptr, stallcw} !== {1'b1, idx, i[3:0], 1'b0}) begin
            errors++; $display("FAIL wrap_fill[%0d] got %h exp %h", i,
               {fill_c_ready, addr0, rbcwptr, stallcw}, {1'b1, idx, i[3:0], 1'b0});
         end
         tick();
         fill_c_valid = 0; drain_c_req = 1;
         @(negedge clock);
         checks++;
         if ({drain_c_gnt, addr1, stallcr, stallcw} !== {1'b1, idx, 2'b00}) begin
            errors++; $display("FAIL wrap_drain[%0d] got %h exp %h", i,
               {drain_c_gnt, addr1, stallcr, stallcw}, {1'b1, idx, 2'b00});
         end
         tick();
         drain_c_req = 0;
      end
      @(negedge clock);
      checks++;
      if ({rbcwptr, rbcrptr, stallcr, stallcw} !== {8'h00, 2'b10}) begin
         errors++; $display("FAIL wrap_end got %h exp %h", {rbcwptr, rbcrptr, stallcr, stallcw}, {8'h00, 2'b10});
      end
      clear_inputs();
   endtask

   task automatic test_flush();
      do_reset();
      enable_run();
      fill_c_valid = 1;
      repeat (3) tick();
      fill_c_valid = 0;
      sb_flush = 1;
      tick();
      sb_flush = 0; fill_c_valid = 1; drain_c_req = 1;
      @(negedge clock);
      checks++;
      if ({fill_c_ready, drain_c_gnt, we0, rbcwptr} !== {3'b000, 4'h3}) begin
         errors++; $display("FAIL flush_cycle got %h exp %h", {fill_c_ready, drain_c_gnt, we0, rbcwptr}, {3'b000, 4'h3});
      end
      tick();
      @(negedge clock);
      checks++;
      if ({fill_c_ready, drain_c_gnt, we0, rbcwptr, rbcrptr, stallcr} !== {3'b000, 8'h00, 1'b1}) begin
         errors++; $display("FAIL flush_idle got %h exp %h",
            {fill_c_ready, drain_c_gnt, we0, rbcwptr, rbcrptr, stallcr}, {3'b000, 8'h00, 1'b1});
      end
      tick();
      @(negedge clock);
      checks++;
      if ({fill_c_ready, drain_c_gnt, addr0} !== {2'b10, 4'h0}) begin
         errors++; $display("FAIL flush_run got %h exp %h", {fill_c_ready, drain_c_gnt, addr0}, {2'b10, 4'h0});
      end
      tick();
      clear_inputs();
   endtask

   task automatic test_reset_mid();
      do_reset();
      enable_run();
      fill_c_valid = 1;
      tick();
      tick();
      #2;
      reset_l = 0;
      #1;
      checks++;
      if ({we0, fill_c_ready, rbcwptr} !== 6'h00) begin
         errors++; $display("FAIL reset_mid got %h exp 00", {we0, fill_c_ready, rbcwptr});
      end
      @(posedge clock);
      #1;
      reset_l = 1;
      fill_c_valid = 0;
      @(negedge clock);
      checks++;
      if ({rbcwptr, stallcr} !== 5'b00001) begin
         errors++; $display("FAIL reset_mid_after got %h exp 01", {rbcwptr, stallcr});
      end
      clear_inputs();
   endtask

   // Model tracks total fills/drains per region as plain counts; pointers are those counts mod 16.
   task automatic test_random();
      int         st, cw, cr, zw, zr;
      logic       lfz, ldz, rdc, rdz, run;
      logic       ce, ze, dce, dze, efc, efz, edc, edz;
      logic [3:0] ea0, ea1;
      logic [36:0] exp_v;
      do_reset();
      st = 0; cw = 0; cr = 0; zw = 0; zr = 0;
      lfz = 1; ldz = 1; rdc = 0; rdz = 0;
      for (int cyc = 0; cyc < 800; cyc++) begin
         sb_enable    = ($urandom_range(0, 15) != 0);
         sb_flush     = ($urandom_range(0, 50) == 0);
         fill_c_valid = ($urandom_range(0, 9) < 6);
         fill_z_valid = ($urandom_range(0, 9) < 5);
         drain_c_req  = ($urandom_range(0, 9) < 5);
         drain_z_req  = ($urandom_range(0, 9) < 6);
         run = (st == 1);
         ce  = run && fill_c_valid && (cw - cr) < 8;
         ze  = run && fill_z_valid && (zw - zr) < 8;
         dce = run && drain_c_req && (cw - cr) > 0;
         dze = run && drain_z_req && (zw - zr) > 0;
         efc = ce && (!ze || lfz);
         efz = ze && !efc;
         edc = dce && (!dze || ldz);
         edz = dze && !edc;
         ea0 = efc ? 4'(cw % 8) : (efz ? 4'(8 + zw % 8) : 4'h0);
         ea1 = edc ? 4'(cr % 8) : (edz ? 4'(8 + zr % 8) : 4'h0);
         exp_v = {efc, efz, edc, edz, efc | efz, 1'b0, efz, rdc, rdz, ea0, ea1,
                  4'(cr % 16), 4'(cw % 16), 4'(zr % 16), 4'(zw % 16),
                  (cw == cr), (cw - cr == 8), (zw == zr), (zw - zr == 8)};
         @(negedge clock);
         checks++;
         if (obs !== exp_v) begin
            errors++; $display("FAIL random[%0d] got %h exp %h", cyc, obs, exp_v);
         end
         if (efc || efz) lfz = efz;
         if (edc || edz) ldz = edz;
         rdc = edc; rdz = edz;
         if (st == 2) begin
            cw = 0; cr = 0; zw = 0; zr = 0; st = 0;
         end else begin
            cw += int'(efc); zw += int'(efz); cr += int'(edc); zr += int'(edz);
            st = sb_flush ? 2 : (sb_enable ? 1 : 0);
         end
         tick();
      end
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      reset_l = 0;
      test_reset();
      test_fill_full();
      test_full_drain();
      test_rr_fill();
      test_empty_z();
      test_wrap();
      test_flush();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
